key_expand_iter: RTL and testbench

- Iterative AES-128 key schedule that produces the 11 round keys (rounds 0..10) one at a time, directly upstream of the round-key XOR stage.
- Each round key is presented as a 4x4 byte matrix in the same [word][byte] layout the round-key XOR stage consumes.
- One shared S-box lookup is used per cycle, so a new key is generated one 32-bit word per cycle.
- Keys are delivered over a valid/ready handshake so the cipher datapath can stall the schedule.

---
 rtl/key_expand_iter_pkg.sv | 66 ++++++
 rtl/key_expand_iter_sub_word.sv | 17 +
 rtl/key_expand_iter.sv | 136 +++++++++++++
 tb/tb_key_expand_iter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_expand_iter_pkg.sv
// Shared AES types and constants for the iterative AES-128 key schedule
// and the neighbouring cipher stages (round-key XOR, SubBytes).
package key_expand_iter_pkg;

    localparam int NR = 10;
    localparam logic [3:0] LAST_ROUND = 4'(NR);

    typedef logic [7:0] aes_byte_t;
    typedef aes_byte_t [3:0] aes_word_t;
    typedef aes_word_t [3:0] aes_key_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_GEN  = 2'd2
    } ks_state_t;

    localparam aes_byte_t SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic aes_byte_t rcon(input logic [3:0] idx);
        aes_byte_t r;
        case (idx)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // Flat 128-bit key (word0 byte0 in the MSBs) into the [word][byte] matrix.
    function automatic aes_key_t key_from_bits(input logic [127:0] bits);
        aes_key_t k;
        for (int w = 0; w < 4; w++) begin
            for (int b = 0; b < 4; b++) begin
                k[w][b] = bits[127 - 8 * (4 * w + b) -: 8];
            end
        end
        return k;
    endfunction

endpackage

// File: rtl/key_expand_iter_sub_word.sv
// Four parallel AES S-box lookups on one 32-bit word (SubWord / SubBytes column).
module key_expand_iter_sub_word
    import key_expand_iter_pkg::*;
(
    input  aes_word_t word_i,
    output aes_word_t word_o
);

    // Bytewise S-box substitution
    always_comb begin
        word_o = '0;
        for (int b = 0; b < 4; b++) begin
            word_o[b] = SBOX[word_i[b]];
        end
    end

endmodule

// File: rtl/key_expand_iter.sv
// Iterative AES-128 key schedule: emits round keys 0..10 over valid/ready,
// rebuilding the key register in place one word per cycle between keys.
module key_expand_iter
    import key_expand_iter_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic         start_ready,
    input  logic [127:0] key_in,
    output logic         rk_valid,
    input  logic         rk_ready,
    output aes_key_t     rk,
    output logic [3:0]   rk_round,
    output logic         rk_last
);

    ks_state_t  state_q, state_d;
    aes_key_t   key_q, key_d;
    logic [3:0] round_q, round_d;
    logic [1:0] k_q, k_d;
    logic       start_ready_q, start_ready_d;
    logic       rk_valid_q, rk_valid_d;
    logic       rk_last_q, rk_last_d;

    aes_word_t  rot_s;
    aes_word_t  sub_s;
    aes_word_t  rcon_s;

    // RotWord of w3 and the Rcon word for the key being generated
    always_comb begin
        rot_s[0] = key_q[3][1];
        rot_s[1] = key_q[3][2];
        rot_s[2] = key_q[3][3];
        rot_s[3] = key_q[3][0];
        rcon_s    = '0;
        rcon_s[0] = rcon(round_q + 4'd1);
    end

    key_expand_iter_sub_word u_sub_word (
        .word_i (rot_s),
        .word_o (sub_s)
    );

    // Next-state and next-output logic
    always_comb begin
        state_d       = state_q;
        key_d         = key_q;
        round_d       = round_q;
        k_d           = k_q;
        start_ready_d = start_ready_q;
        rk_valid_d    = rk_valid_q;
        rk_last_d     = rk_last_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    key_d         = key_from_bits(key_in);
                    round_d       = 4'd0;
                    state_d       = ST_EMIT;
                    start_ready_d = 1'b0;
                    rk_valid_d    = 1'b1;
                    rk_last_d     = 1'b0;
                end else begin
                    start_ready_d = 1'b1;
                end
            end
            ST_EMIT: begin
                if (rk_ready) begin
                    rk_valid_d = 1'b0;
                    rk_last_d  = 1'b0;
                    k_d        = 2'd0;
                    if (round_q == LAST_ROUND) begin
                        state_d       = ST_IDLE;
                        start_ready_d = 1'b1;
                    end else begin
                        state_d = ST_GEN;
                    end
                end else begin
                    rk_valid_d = 1'b1;
                end
            end
            ST_GEN: begin
                // Words are updated in place, so w(k-1) is already the new value
                case (k_q)
                    2'd0:    key_d[0] = key_q[0] ^ sub_s ^ rcon_s;
                    2'd1:    key_d[1] = key_q[1] ^ key_q[0];
                    2'd2:    key_d[2] = key_q[2] ^ key_q[1];
                    default: key_d[3] = key_q[3] ^ key_q[2];
                endcase
                k_d = k_q + 2'd1;
                if (k_q == 2'd3) begin
                    state_d    = ST_EMIT;
                    round_d    = round_q + 4'd1;
                    rk_valid_d = 1'b1;
                    rk_last_d  = (round_q == (LAST_ROUND - 4'd1));
                end else begin
                    rk_valid_d = 1'b0;
                end
            end
            default: begin
                state_d       = ST_IDLE;
                start_ready_d = 1'b1;
                rk_valid_d    = 1'b0;
                rk_last_d     = 1'b0;
            end
        endcase
    end

    // State, key and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            key_q         <= '0;
            round_q       <= 4'd0;
            k_q           <= 2'd0;
            start_ready_q <= 1'b1;
            rk_valid_q    <= 1'b0;
            rk_last_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            key_q         <= key_d;
            round_q       <= round_d;
            k_q           <= k_d;
            start_ready_q <= start_ready_d;
            rk_valid_q    <= rk_valid_d;
            rk_last_q     <= rk_last_d;
        end
    end

    assign start_ready = start_ready_q;
    assign rk_valid    = rk_valid_q;
    assign rk          = key_q;
    assign rk_round    = round_q;
    assign rk_last     = rk_last_q;

endmodule

// File: tb/tb_key_expand_iter.sv
// Self-checking bench for key_expand_iter against a word-level FIPS-197 key
// expansion model whose S-box is derived from GF(2^8) inversion.
module tb_key_expand_iter;
    import key_expand_iter_pkg::*;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         start_ready;
    logic [127:0] key_in = 128'h0;
    logic         rk_valid;
    logic         rk_ready = 1'b0;
    aes_key_t     rk;
    logic [3:0]   rk_round;
    logic         rk_last;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]   sbox_m [256];
    logic [127:0] model_key [11];

    logic [127:0] got_key   [11];
    logic [3:0]   got_round [11];
    logic         got_last  [11];
    int           hs_cyc    [11];
    int           n_hs;
    bit           timed_out, stall_bad, last_bad, sr_at_last;

    key_expand_iter dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .start_ready (start_ready),
        .key_in      (key_in),
        .rk_valid    (rk_valid),
        .rk_ready    (rk_ready),
        .rk          (rk),
        .rk_round    (rk_round),
        .rk_last     (rk_last)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gf_mul(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
            end
            sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // Standard 44-word expansion, word i stored big-endian (byte0 in MSBs)
    task automatic build_model(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
                t = t ^ {rc, 24'h0};
                rc = rc[7] ? ((rc << 1) ^ 8'h1b) : (rc << 1);
            end
            w[i] = w[i - 4] ^ t;
        end
        for (int r = 0; r < 11; r++) model_key[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    endtask

    function automatic logic [127:0] flat(input aes_key_t k);
        logic [127:0] f;
        for (int w = 0; w < 4; w++)
            for (int b = 0; b < 4; b++)
                f[127 - 8 * (4 * w + b) -: 8] = k[w][b];
        return f;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        start = 1'b0; rk_ready = 1'b0; key_in = 128'h0;
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        step();
    endtask

    // Drives one full schedule and records every handshake (slot cyc hands over at edge cyc+1)
    task automatic collect(input logic [127:0] key, input int ready_pct, input int stall_round,
                           input int stall_len, input bit pulse_gen, input bit b2b,
                           input logic [127:0] alt_key);
        int cyc = 0;
        bit pulsed = 1'b0;
        bit stalled = 1'b0;
        aes_key_t snap;
        logic [3:0] snap_r;
        n_hs = 0; timed_out = 1'b0; stall_bad = 1'b0; last_bad = 1'b0; sr_at_last = 1'b0;
        key_in = key; start = 1'b1; rk_ready = 1'b0;
        step();
        start = 1'b0;
        while (n_hs < 11) begin
            if (cyc > 600) begin
                timed_out = 1'b1;
                break;
            end
            if (stall_round >= 0 && !stalled && rk_valid && rk_round == stall_round[3:0]) begin
                stalled = 1'b1;
                snap = rk; snap_r = rk_round;
                for (int i = 0; i < stall_len; i++) begin
                    rk_ready = 1'b0;
                    if (!rk_valid || rk !== snap || rk_round !== snap_r) stall_bad = 1'b1;
                    step(); cyc++;
                end
            end
            if (pulse_gen && !pulsed && n_hs == 3 && !rk_valid) begin
                start = 1'b1; key_in = alt_key; pulsed = 1'b1;
            end else begin
                start = 1'b0; key_in = key;
            end
            rk_ready = ($urandom_range(99) < ready_pct);
            if (rk_valid && (rk_last !== (rk_round == 4'd10))) last_bad = 1'b1;
            if (rk_valid && rk_ready) begin
                got_key[n_hs] = flat(rk); got_round[n_hs] = rk_round;
                got_last[n_hs] = rk_last; hs_cyc[n_hs] = cyc + 1;
                n_hs++;
                if (n_hs == 11 && b2b) begin
                    sr_at_last = start_ready; start = 1'b1; key_in = alt_key;
                end
            end
            step(); cyc++;
        end
        rk_ready = 1'b0;
        if (!b2b) start = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++; if (start_ready !== 1'b1) begin n_fail++; $display("FAIL reset_start_ready: got %b want 1", start_ready); end
        n_tests++; if (rk_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rk_valid: got %b want 0", rk_valid); end
        n_tests++; if (flat(rk) !== 128'h0) begin n_fail++; $display("FAIL reset_rk: got %h want 0", flat(rk)); end
        n_tests++; if (rk_round !== 4'd0 || rk_last !== 1'b0) begin n_fail++; $display("FAIL reset_round_last: got %0d/%b want 0/0", rk_round, rk_last); end
    endtask

    task automatic test_fips();
        do_reset();
        build_model(FIPS_KEY);
        collect(FIPS_KEY, 100, -1, 0, 1'b0, 1'b0, 128'h0);
        n_tests++; if (timed_out) begin n_fail++; $display("FAIL fips_timeout: got %0d handshakes want 11", n_hs); end
        n_tests++; if (model_key[1] !== FIPS_R1 || model_key[10] !== FIPS_R10) begin n_fail++; $display("FAIL fips_model: got %h want %h", model_key[1], FIPS_R1); end
        n_tests++; if (got_key[0] !== FIPS_KEY) begin n_fail++; $display("FAIL fips_r0: got %h want %h", got_key[0], FIPS_KEY); end
        n_tests++; if (got_key[1] !== FIPS_R1) begin n_fail++; $display("FAIL fips_r1: got %h want %h", got_key[1], FIPS_R1); end
        n_tests++; if (got_key[10] !== FIPS_R10) begin n_fail++; $display("FAIL fips_r10: got %h want %h", got_key[10], FIPS_R10); end
        for (int r = 0; r < 11; r++) begin
            n_tests++;
            if (got_key[r] !== model_key[r] || got_round[r] !== r[3:0] || got_last[r] !== (r == 10) || hs_cyc[r] !== 1 + 5 * r) begin
                n_fail++;
                $display("FAIL fips_round%0d: got key %h rnd %0d last %b edge E%0d want %h %0d %b E%0d",
                         r, got_key[r], got_round[r], got_last[r], hs_cyc[r], model_key[r], r, r == 10, 1 + 5 * r);
            end
        end
        n_tests++; if (last_bad) begin n_fail++; $display("FAIL fips_rk_last: got mismatch want rk_last==(round==10)"); end
        n_tests++; if (start_ready !== 1'b1) begin n_fail++; $display("FAIL fips_start_ready_after: got %b want 1", start_ready); end
    endtask

    task automatic test_zero_key();
        do_reset();
        collect(128'h0, 100, -1, 0, 1'b0, 1'b0, 128'h0);
        n_tests++; if (got_key[0] !== 128'h0) begin n_fail++; $display("FAIL zero_r0: got %h want 0", got_key[0]); end
        n_tests++; if (got_key[1] !== ZERO_R1) begin n_fail++; $display("FAIL zero_r1: got %h want %h", got_key[1], ZERO_R1); end
        n_tests++; if (got_key[10] !== ZERO_R10) begin n_fail++; $display("FAIL zero_r10: got %h want %h", got_key[10], ZERO_R10); end
    endtask

    task automatic test_random_keys();
        logic [127:0] key;
        for (int t = 0; t < 4; t++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            do_reset();
            build_model(key);
            collect(key, 55, -1, 0, 1'b0, 1'b0, 128'h0);
            n_tests++; if (timed_out) begin n_fail++; $display("FAIL rand_timeout: got %0d handshakes want 11", n_hs); end
            for (int r = 0; r < 11; r++) begin
                n_tests++;
                if (got_key[r] !== model_key[r] || got_round[r] !== r[3:0] || got_last[r] !== (r == 10)) begin
                    n_fail++;
                    $display("FAIL rand_key%0d_round%0d: got %h rnd %0d last %b want %h %0d %b",
                             t, r, got_key[r], got_round[r], got_last[r], model_key[r], r, r == 10);
                end
            end
            n_tests++; if (last_bad) begin n_fail++; $display("FAIL rand_rk_last: got mismatch want rk_last==(round==10)"); end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        build_model(FIPS_KEY);
        collect(FIPS_KEY, 100, 3, 7, 1'b0, 1'b0, 128'h0);
        n_tests++; if (stall_bad) begin n_fail++; $display("FAIL bp_stable: got change during stall want rk/rk_round/rk_valid held"); end
        n_tests++; if (hs_cyc[3] !== 23) begin n_fail++; $display("FAIL bp_delayed_hs: got E%0d want E23", hs_cyc[3]); end
        n_tests++; if (hs_cyc[4] - hs_cyc[3] !== 5) begin n_fail++; $display("FAIL bp_resume_gap: got %0d want 5", hs_cyc[4] - hs_cyc[3]); end
        n_tests++; if (got_key[3] !== model_key[3] || got_key[4] !== model_key[4]) begin n_fail++; $display("FAIL bp_r4: got %h want %h", got_key[4], model_key[4]); end
    endtask

    task automatic test_start_during_gen();
        do_reset();
        build_model(FIPS_KEY);
        collect(FIPS_KEY, 100, -1, 0, 1'b1, 1'b0, 128'hdeadbeef_01234567_89abcdef_55aa55aa);
        for (int r = 0; r < 11; r++) begin
            n_tests++;
            if (got_key[r] !== model_key[r]) begin n_fail++; $display("FAIL gen_start_r%0d: got %h want %h", r, got_key[r], model_key[r]); end
        end
    endtask

    task automatic test_async_reset();
        bit reached = 1'b0;
        do_reset();
        key_in = FIPS_KEY; start = 1'b1;
        step();
        start = 1'b0; rk_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (rk_valid && rk_round == 4'd5) begin
                reached = 1'b1;
                break;
            end
            step();
        end
        n_tests++; if (!reached) begin n_fail++; $display("FAIL arst_reach: got no round 5 want round 5 in 100 cycles"); end
        step();
        step();
        #2 rst = 1'b0;
        #1;
        n_tests++;
        if (rk_valid !== 1'b0 || start_ready !== 1'b1 || flat(rk) !== 128'h0 || rk_round !== 4'd0 || rk_last !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_clear: got valid %b ready %b rk %h rnd %0d last %b want 0 1 0 0 0",
                     rk_valid, start_ready, flat(rk), rk_round, rk_last);
        end
        rk_ready = 1'b0;
        #1 rst = 1'b1;
        step();
        collect(FIPS_KEY, 100, -1, 0, 1'b0, 1'b0, 128'h0);
        n_tests++; if (got_key[1] !== FIPS_R1) begin n_fail++; $display("FAIL arst_restart_r1: got %h want %h", got_key[1], FIPS_R1); end
    endtask

    task automatic test_back_to_back();
        logic [127:0] nk = 128'h000102030405060708090a0b0c0d0e0f;
        do_reset();
        collect(FIPS_KEY, 100, -1, 0, 1'b0, 1'b1, nk);
        n_tests++; if (sr_at_last !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_at_last: got %b want 0", sr_at_last); end
        n_tests++; if (start_ready !== 1'b1 || rk_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got ready %b valid %b want 1 0", start_ready, rk_valid); end
        step();
        start = 1'b0;
        n_tests++;
        if (rk_valid !== 1'b1 || rk_round !== 4'd0 || flat(rk) !== nk || start_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_new_r0: got valid %b rnd %0d rk %h ready %b want 1 0 %h 0",
                     rk_valid, rk_round, flat(rk), start_ready, nk);
        end
    endtask

    initial begin
        build_sbox();
        test_reset();
        test_fips();
        test_zero_key();
        test_random_keys();
        test_backpressure();
        test_start_during_gen();
        test_async_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
